pipe_tap_chain: RTL and testbench

Parametrised multi-stage pipeline register chain with run-time latency selection and per-stage valid tracking. It replaces single-stage optional register slices on the DSP datapath (A/B/C/D/M/P input and output staging) wherever a configurable delay of 0..DEPTH cycles is needed. It adds shared clock-enable stall, a synchronous flush and an occupancy counter.

---
 rtl/pipe_tap_chain.sv | 84 ++++++++
 tb/tb_pipe_tap_chain.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_tap_chain.sv
// pipe_tap_chain: configurable-latency register chain with per-stage valid
// bits, a shared clock-enable stall, a synchronous flush and an occupancy
// counter. The output tap is chosen at run time from 0 (bypass) to DEPTH.

module pipe_tap_chain #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             flush,
  input  logic [WIDTH-1:0] X,
  input  logic             X_vld,
  input  logic [LW-1:0]    lat,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic [LW-1:0]    occ
);

  localparam logic [LW-1:0] MaxTap = LW'(DEPTH);

  logic [WIDTH-1:0] data_q [1:DEPTH];
  logic [WIDTH-1:0] data_d [1:DEPTH];
  logic [DEPTH:1]   vld_q;
  logic [DEPTH:1]   vld_d;
  logic [LW-1:0]    occ_q;
  logic [LW-1:0]    occ_d;
  logic [LW-1:0]    eff;

  // Next-state: flush clears everything, otherwise shift when enabled, else hold.
  // The counter tracks entries in minus the valid bit falling off the end,
  // so it stays equal to the number of set valid bits without a popcount.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (flush) begin
      data_d = '{default: '0};
      vld_d  = '0;
      occ_d  = '0;
    end else if (cen) begin
      data_d[1] = X;
      vld_d[1]  = X_vld;
      for (int k = 2; k <= DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      occ_d = occ_q + LW'(X_vld) - LW'(vld_q[DEPTH]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '{default: '0};
      vld_q  <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      occ_q  <= occ_d;
    end
  end

  // Requested latencies beyond the chain length clamp to the last stage.
  assign eff = (lat > MaxTap) ? MaxTap : lat;

  // Output tap select; tap 0 is the combinational bypass of the input.
  always_comb begin
    out     = X;
    out_vld = X_vld;
    for (int k = 1; k <= DEPTH; k++) begin
      if (eff == LW'(k)) begin
        out     = data_q[k];
        out_vld = vld_q[k];
      end
    end
  end

  assign occ = occ_q;

endmodule

// File: tb/tb_pipe_tap_chain.sv
// Testbench for pipe_tap_chain: three instances (default, smallest and
// largest configuration) compared against a queue-style history model.

module tb_pipe_tap_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        flush;
  logic [47:0] xIn;
  logic        xVld;

  logic [2:0]  lat0;
  logic [0:0]  lat1;
  logic [4:0]  lat2;

  logic [17:0] out0;
  logic [0:0]  out1;
  logic [47:0] out2;
  logic        vld0, vld1, vld2;
  logic [2:0]  occ0;
  logic [0:0]  occ1;
  logic [4:0]  occ2;

  int checkCount = 0;
  int passCount  = 0;

  // History model: entry [id][j] is the sample captured j+1 enabled edges ago.
  logic [47:0] mData [3][16];
  logic        mVld  [3][16];

  pipe_tap_chain #(.WIDTH(18), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .cen(cen), .flush(flush),
    .X(xIn[17:0]), .X_vld(xVld), .lat(lat0),
    .out(out0), .out_vld(vld0), .occ(occ0)
  );

  pipe_tap_chain #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .cen(cen), .flush(flush),
    .X(xIn[0:0]), .X_vld(xVld), .lat(lat1),
    .out(out1), .out_vld(vld1), .occ(occ1)
  );

  pipe_tap_chain #(.WIDTH(48), .DEPTH(16)) dut2 (
    .clk(clk), .rst(rst), .cen(cen), .flush(flush),
    .X(xIn), .X_vld(xVld), .lat(lat2),
    .out(out2), .out_vld(vld2), .occ(occ2)
  );

  always #5 clk = ~clk;

  function automatic int depthOf(input int id);
    case (id)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] maskOf(input int id);
    case (id)
      0:       return (64'd1 << 18) - 64'd1;
      1:       return 64'd1;
      default: return (64'd1 << 48) - 64'd1;
    endcase
  endfunction

  function automatic void modelClear(input int id);
    for (int j = 0; j < 16; j++) begin
      mData[id][j] = '0;
      mVld[id][j]  = 1'b0;
    end
  endfunction

  function automatic void modelPush(input int id);
    for (int j = depthOf(id) - 1; j > 0; j--) begin
      mData[id][j] = mData[id][j-1];
      mVld[id][j]  = mVld[id][j-1];
    end
    mData[id][0] = 48'(64'(xIn) & maskOf(id));
    mVld[id][0]  = xVld;
  endfunction

  function automatic logic [63:0] expOut(input int id, input int latv);
    int eff;
    eff = (latv > depthOf(id)) ? depthOf(id) : latv;
    if (eff == 0) return 64'(xIn) & maskOf(id);
    return 64'(mData[id][eff-1]);
  endfunction

  function automatic logic [63:0] expVld(input int id, input int latv);
    int eff;
    eff = (latv > depthOf(id)) ? depthOf(id) : latv;
    if (eff == 0) return 64'(xVld);
    return 64'(mVld[id][eff-1]);
  endfunction

  function automatic logic [63:0] expOcc(input int id);
    int n;
    n = 0;
    for (int j = 0; j < depthOf(id); j++) n += int'(mVld[id][j]);
    return 64'(n);
  endfunction

  // Drive one cycle's worth of inputs; the caller advances time afterwards.
  task automatic applyStimulus(input logic cenV, input logic flushV,
                               input logic [47:0] xV, input logic xvV);
    cen   = cenV;
    flush = flushV;
    xIn   = xV;
    xVld  = xvV;
  endtask

  // Advance one rising edge, update the model, and land 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int id = 0; id < 3; id++) begin
      if (rst || flush) modelClear(id);
      else if (cen)     modelPush(id);
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Compare every instance's outputs against the model.
  task automatic checkModel(input string stepName);
    for (int id = 0; id < 3; id++) begin
      logic [63:0] obsOut, obsVld, obsOcc;
      int latv;
      case (id)
        0: begin obsOut = 64'(out0); obsVld = 64'(vld0); obsOcc = 64'(occ0); latv = int'(lat0); end
        1: begin obsOut = 64'(out1); obsVld = 64'(vld1); obsOcc = 64'(occ1); latv = int'(lat1); end
        default: begin obsOut = 64'(out2); obsVld = 64'(vld2); obsOcc = 64'(occ2); latv = int'(lat2); end
      endcase
      checkOutput($sformatf("%s.d%0d.out", stepName, id), obsOut, expOut(id, latv));
      checkOutput($sformatf("%s.d%0d.vld", stepName, id), obsVld, expVld(id, latv));
      checkOutput($sformatf("%s.d%0d.occ", stepName, id), obsOcc, expOcc(id));
    end
  endtask

  initial begin
    logic [63:0] rnd;
    int occExp [6];
    logic vPat [6];

    for (int id = 0; id < 3; id++) modelClear(id);

    // Reset held with the bypass tap selected.
    rst  = 1'b1;
    lat0 = 3'd0; lat1 = 1'b0; lat2 = 5'd0;
    applyStimulus(1'b0, 1'b0, 48'h1234, 1'b1);
    #2;
    $display("[TB] reset and bypass");
    checkOutput("bypass.out", 64'(out0), 64'h1234);
    checkOutput("bypass.vld", 64'(vld0), 64'd1);
    checkOutput("reset.occ", 64'(occ0), 64'd0);
    checkModel("reset");
    lat0 = 3'd3;
    #1;
    checkOutput("reset.tap3.out", 64'(out0), 64'd0);
    checkOutput("reset.tap3.vld", 64'(vld0), 64'd0);
    lat0 = 3'd0;
    rst  = 1'b0;

    // Fill three stages, then assert reset between edges.
    applyStimulus(1'b1, 1'b0, 48'h1234, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("fill.occ", 64'(occ0), 64'd3);
    #3;
    rst = 1'b1;
    for (int id = 0; id < 3; id++) modelClear(id);
    #1;
    checkOutput("asyncrst.occ0", 64'(occ0), 64'd0);
    checkOutput("asyncrst.occ2", 64'(occ2), 64'd0);
    checkModel("asyncrst");
    #1;
    rst = 1'b0;

    // Latency sweep with a ramp; 7 must behave as the deepest tap.
    $display("[TB] latency sweep");
    for (int l = 1; l <= 5; l++) begin
      lat0 = (l == 5) ? 3'd7 : 3'(l);
      lat2 = 5'($urandom_range(0, 31));
      lat1 = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, 1'b1, 48'd0, 1'b0);
      tick();
      for (int n = 1; n <= 7; n++) begin
        applyStimulus(1'b1, 1'b0, 48'(n), 1'b1);
        tick();
        checkModel($sformatf("sweep.l%0d.n%0d", int'(lat0), n));
      end
    end

    // Stall: freeze after sample 5 is captured, junk offered meanwhile.
    $display("[TB] stall");
    lat0 = 3'd2;
    applyStimulus(1'b1, 1'b1, 48'd0, 1'b0);
    tick();
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(1'b1, 1'b0, 48'(n), 1'b1);
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      rnd = {$urandom(), $urandom()};
      applyStimulus(1'b0, 1'b0, rnd[47:0] | 48'h100, 1'b1);
      tick();
      checkOutput($sformatf("stall%0d.out", s), 64'(out0), 64'd4);
      checkOutput($sformatf("stall%0d.occ", s), 64'(occ0), 64'd4);
      checkModel($sformatf("stall%0d", s));
    end
    applyStimulus(1'b1, 1'b0, 48'd6, 1'b1);
    tick();
    checkOutput("resume6.out", 64'(out0), 64'd5);
    applyStimulus(1'b1, 1'b0, 48'd7, 1'b1);
    tick();
    checkOutput("resume7.out", 64'(out0), 64'd6);

    // Occupancy from empty, valid pattern 1,0,1,1,1,1. Following the shift
    // rule, edge 5 drops the valid sample from edge 1 (occ stays 3) and edge 6
    // drops the invalid sample from edge 2, so occ reaches 4.
    $display("[TB] occupancy");
    lat0 = 3'd4;
    applyStimulus(1'b1, 1'b1, 48'd0, 1'b0);
    tick();
    vPat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    occExp = '{1, 1, 2, 3, 3, 4};
    for (int e = 0; e < 6; e++) begin
      applyStimulus(1'b1, 1'b0, 48'(e + 32), vPat[e]);
      tick();
      checkOutput($sformatf("occ.e%0d", e + 1), 64'(occ0), 64'(occExp[e]));
      checkModel($sformatf("occ.e%0d", e + 1));
    end

    // Flush with enable on a full chain: the offered sample must be dropped.
    $display("[TB] flush priority");
    applyStimulus(1'b1, 1'b1, 48'hABC, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 48'h0, 1'b0);
    checkOutput("flush.occ", 64'(occ0), 64'd0);
    for (int l = 1; l <= 4; l++) begin
      lat0 = 3'(l);
      #1;
      checkOutput($sformatf("flush.tap%0d.out", l), 64'(out0), 64'd0);
      checkOutput($sformatf("flush.tap%0d.vld", l), 64'(vld0), 64'd0);
    end
    for (int n = 0; n < 4; n++) begin
      tick();
      checkModel($sformatf("postflush%0d", n));
    end

    // Deepest configuration: 16-cycle delay and full occupancy.
    $display("[TB] depth 16");
    lat2 = 5'd16;
    applyStimulus(1'b1, 1'b1, 48'd0, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 48'(100 + i), 1'b1);
      tick();
      if (i == 14) checkOutput("d16.early.vld", 64'(vld2), 64'd0);
    end
    checkOutput("d16.out", 64'(out2), 64'd100);
    checkOutput("d16.vld", 64'(vld2), 64'd1);
    checkOutput("d16.occ", 64'(occ2), 64'd16);

    // Single-stage configuration: occ toggles with the valid bit.
    $display("[TB] depth 1");
    lat1 = 1'b1;
    applyStimulus(1'b1, 1'b1, 48'd0, 1'b0);
    tick();
    for (int e = 0; e < 3; e++) begin
      applyStimulus(1'b1, 1'b0, 48'(e == 1 ? 0 : 1), (e != 1));
      tick();
      checkOutput($sformatf("d1.e%0d.occ", e), 64'(occ1), (e == 1) ? 64'd0 : 64'd1);
      checkOutput($sformatf("d1.e%0d.out", e), 64'(out1), (e == 1) ? 64'd0 : 64'd1);
    end

    // Randomized traffic on all instances, including stalls, flushes and
    // tap changes between cycles.
    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      rnd  = {$urandom(), $urandom()};
      lat0 = 3'($urandom_range(0, 7));
      lat1 = 1'($urandom_range(0, 1));
      lat2 = 5'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                    rnd[47:0], 1'($urandom_range(0, 1)));
      #1;
      checkModel($sformatf("rnd%0d.pre", c));
      tick();
      checkModel($sformatf("rnd%0d.post", c));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
